// File: rtl/wb_stage_pipe_pkg.sv
// Shared definitions for the MEM/WB write-back stage: write-back source
// encodings, load-type encodings and default datapath widths.
package wb_stage_pipe_pkg;

  localparam int WB_DATA_W_DEF     = 32;
  localparam int WB_REG_ADDR_W_DEF = 5;
  localparam int WB_SRC_W          = 2;
  localparam int LD_TYPE_W         = 3;

  // Write-back source select carried on MemToReg.
  typedef enum logic [WB_SRC_W-1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_PC   = 2'd2,
    WB_SRC_ZERO = 2'd3
  } wb_src_e;

  // Load width/extension carried on LoadType; unlisted codes act as LD_W.
  typedef enum logic [LD_TYPE_W-1:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB bus: MEM-stage results going into the stage and the
// register-file write port / forwarding bus coming out of it.
// There is no handshake: the bus is sampled every unstalled cycle, and the
// WB-side signals are valid whenever WBValid is high; WBRegWrite is already
// qualified and may be used directly as the register-file write enable.
interface wb_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // MEM-stage side
  logic                  InValid;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [1:0]            MemToReg;
  logic [2:0]            LoadType;
  logic [1:0]            ByteOffset;
  logic [DATA_W-1:0]     ALUResult;
  logic [DATA_W-1:0]     ReadData;
  logic [DATA_W-1:0]     PC;
  // WB-stage side
  logic                  WBValid;
  logic                  WBRegWrite;
  logic [REG_ADDR_W-1:0] WBWriteReg;
  logic [DATA_W-1:0]     WBWriteData;

  // Upstream producer / downstream consumer of the stage.
  modport master (
    output InValid, RegWrite, WriteReg, MemToReg, LoadType, ByteOffset,
           ALUResult, ReadData, PC,
    input  WBValid, WBRegWrite, WBWriteReg, WBWriteData
  );

  // The write-back stage itself.
  modport slave (
    input  InValid, RegWrite, WriteReg, MemToReg, LoadType, ByteOffset,
           ALUResult, ReadData, PC,
    output WBValid, WBRegWrite, WBWriteReg, WBWriteData
  );
endinterface

// File: rtl/wb_stage_pipe_load_formatter.sv
// Purely combinational sub-word load formatter (little-endian).
// Picks the addressed byte or halfword out of the raw memory word and
// sign- or zero-extends it; LW and unlisted codes pass the word through.
module wb_stage_pipe_load_formatter
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W_DEF
) (
  input  logic [DATA_W-1:0]    read_data_i,
  input  logic [LD_TYPE_W-1:0] load_type_i,
  input  logic [1:0]           byte_offset_i,
  output logic [DATA_W-1:0]    data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane extraction; the low offset bit is ignored for halfwords.
  always_comb begin
    byte_lane = read_data_i[{byte_offset_i, 3'b000} +: 8];
    half_lane = read_data_i[{byte_offset_i[1], 4'b0000} +: 16];
  end

  // Width and extension selection.
  always_comb begin
    data_o = read_data_i;
    case (load_type_i)
      LD_B:    data_o = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_lane};
      LD_H:    data_o = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_lane};
      default: data_o = read_data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered MEM/WB write-back stage. One pipeline register with
// flush (priority) and stall; outputs derive only from registered fields,
// so the stage adds exactly one cycle and has no input-to-output path.
// Optional feature macro: WB_PERF_CNT_EN adds RetireCount/BubbleCount.
module wb_stage_pipe
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W           = WB_DATA_W_DEF,
  parameter int REG_ADDR_W       = WB_REG_ADDR_W_DEF,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Stall,
  input  logic           Flush,
  wb_stage_pipe_if.slave bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]    RetireCount,
  output logic [31:0]    BubbleCount
`endif
);

  localparam bit ZeroProtect = (ZERO_REG_PROTECT != 0);

  // Stage register fields
  logic                  valid_q,       valid_d;
  logic                  reg_write_q,   reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q,   write_reg_d;
  logic [WB_SRC_W-1:0]   mem_to_reg_q,  mem_to_reg_d;
  logic [LD_TYPE_W-1:0]  load_type_q,   load_type_d;
  logic [1:0]            byte_offset_q, byte_offset_d;
  logic [DATA_W-1:0]     alu_result_q,  alu_result_d;
  logic [DATA_W-1:0]     read_data_q,   read_data_d;
  logic [DATA_W-1:0]     pc_q,          pc_d;

  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     src_data;
  logic                  dest_is_zero;

  // Next-state: flush inserts a bubble, stall holds, otherwise capture.
  always_comb begin
    valid_d       = valid_q;
    reg_write_d   = reg_write_q;
    write_reg_d   = write_reg_q;
    mem_to_reg_d  = mem_to_reg_q;
    load_type_d   = load_type_q;
    byte_offset_d = byte_offset_q;
    alu_result_d  = alu_result_q;
    read_data_d   = read_data_q;
    pc_d          = pc_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (!Stall) begin
      valid_d       = bus.InValid;
      reg_write_d   = bus.RegWrite;
      write_reg_d   = bus.WriteReg;
      mem_to_reg_d  = bus.MemToReg;
      load_type_d   = bus.LoadType;
      byte_offset_d = bus.ByteOffset;
      alu_result_d  = bus.ALUResult;
      read_data_d   = bus.ReadData;
      pc_d          = bus.PC;
    end
  end

  // Stage register; reset discards any instruction in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      write_reg_q   <= '0;
      mem_to_reg_q  <= '0;
      load_type_q   <= '0;
      byte_offset_q <= '0;
      alu_result_q  <= '0;
      read_data_q   <= '0;
      pc_q          <= '0;
    end else begin
      valid_q       <= valid_d;
      reg_write_q   <= reg_write_d;
      write_reg_q   <= write_reg_d;
      mem_to_reg_q  <= mem_to_reg_d;
      load_type_q   <= load_type_d;
      byte_offset_q <= byte_offset_d;
      alu_result_q  <= alu_result_d;
      read_data_q   <= read_data_d;
      pc_q          <= pc_d;
    end
  end

  wb_stage_pipe_load_formatter #(
    .DATA_W(DATA_W)
  ) u_load_formatter (
    .read_data_i  (read_data_q),
    .load_type_i  (load_type_q),
    .byte_offset_i(byte_offset_q),
    .data_o       (load_data)
  );

  // Write-back source select.
  always_comb begin
    src_data = '0;
    case (mem_to_reg_q)
      WB_SRC_ALU:  src_data = alu_result_q;
      WB_SRC_MEM:  src_data = load_data;
      WB_SRC_PC:   src_data = pc_q;
      WB_SRC_ZERO: src_data = '0;
      default:     src_data = '0;
    endcase
  end

  // Output qualification: bubbles never write and present zero data.
  always_comb begin
    dest_is_zero    = (write_reg_q == '0);
    bus.WBValid     = valid_q;
    bus.WBRegWrite  = valid_q & reg_write_q & ~(ZeroProtect & dest_is_zero);
    bus.WBWriteReg  = write_reg_q;
    bus.WBWriteData = valid_q ? src_data : '0;
  end

`ifdef WB_PERF_CNT_EN
  logic        hold;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // A cycle counts only when the register advances, so a stalled
  // instruction or bubble is counted once, when it leaves.
  always_comb begin
    hold         = Stall & ~Flush;
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!hold) begin
      if (valid_q) retire_cnt_d = retire_cnt_q + 32'd1;
      else         bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retire_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign RetireCount = retire_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: two instances (zero-register protection on and
// off) driven with the same directed vectors; expected outputs are pushed
// by the driver and popped by an independent monitor one cycle later.
module tb_wb_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = 3 + AW + DW;

  logic clk;
  logic rst;
  logic stall;
  logic flush;

  int checks = 0;
  int errors = 0;
  int mon_n  = 0;

  logic [EW-1:0] exp_q[$];

  wb_stage_pipe_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus0 ();
  wb_stage_pipe_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus1 ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire0, bubble0, retire1, bubble1;
`endif

  wb_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_PROTECT(1)) dut0 (
    .Clk  (clk),
    .Rst  (rst),
    .Stall(stall),
    .Flush(flush),
    .bus  (bus0)
`ifdef WB_PERF_CNT_EN
    ,
    .RetireCount(retire0),
    .BubbleCount(bubble0)
`endif
  );

  wb_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_PROTECT(0)) dut1 (
    .Clk  (clk),
    .Rst  (rst),
    .Stall(stall),
    .Flush(flush),
    .bus  (bus1)
`ifdef WB_PERF_CNT_EN
    ,
    .RetireCount(retire1),
    .BubbleCount(bubble1)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Apply one set of inputs to both instances and queue the outputs
  // expected after the next rising edge.
  task automatic drive(
    input logic        v, input logic rw, input logic [AW-1:0] wr,
    input logic [1:0]  m2r, input logic [2:0] lt, input logic [1:0] off,
    input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc,
    input logic        st, input logic fl,
    input logic        ev, input logic erw, input logic erw_np,
    input logic [AW-1:0] ereg, input logic [31:0] edata);
    bus0.InValid = v;   bus1.InValid = v;
    bus0.RegWrite = rw; bus1.RegWrite = rw;
    bus0.WriteReg = wr; bus1.WriteReg = wr;
    bus0.MemToReg = m2r; bus1.MemToReg = m2r;
    bus0.LoadType = lt; bus1.LoadType = lt;
    bus0.ByteOffset = off; bus1.ByteOffset = off;
    bus0.ALUResult = alu; bus1.ALUResult = alu;
    bus0.ReadData = rd; bus1.ReadData = rd;
    bus0.PC = pc; bus1.PC = pc;
    stall = st;
    flush = fl;
    exp_q.push_back({ev, erw, erw_np, ereg, edata});
  endtask

  task automatic cyc(
    input logic        v, input logic rw, input logic [AW-1:0] wr,
    input logic [1:0]  m2r, input logic [2:0] lt, input logic [1:0] off,
    input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc,
    input logic        st, input logic fl,
    input logic        ev, input logic erw, input logic erw_np,
    input logic [AW-1:0] ereg, input logic [31:0] edata);
    @(negedge clk);
    drive(v, rw, wr, m2r, lt, off, alu, rd, pc, st, fl, ev, erw, erw_np, ereg, edata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".WBValid"},     32'(bus0.WBValid),     32'd0);
    check({tag, ".WBRegWrite"},  32'(bus0.WBRegWrite),  32'd0);
    check({tag, ".WBWriteReg"},  32'(bus0.WBWriteReg),  32'd0);
    check({tag, ".WBWriteData"}, bus0.WBWriteData,      32'd0);
    check({tag, ".np_WBRegWrite"}, 32'(bus1.WBRegWrite), 32'd0);
  endtask

  // Monitor: compare outputs just after each rising edge against the queue.
  always @(posedge clk) begin
    logic [EW-1:0]   e;
    logic            ev, erw, erw_np;
    logic [AW-1:0]   ereg;
    logic [31:0]     edata;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      {ev, erw, erw_np, ereg, edata} = e;
      mon_n++;
      check($sformatf("v%0d.WBValid", mon_n),     32'(bus0.WBValid),    32'(ev));
      check($sformatf("v%0d.WBRegWrite", mon_n),  32'(bus0.WBRegWrite), 32'(erw));
      check($sformatf("v%0d.WBWriteData", mon_n), bus0.WBWriteData,     edata);
      check($sformatf("v%0d.np_WBRegWrite", mon_n), 32'(bus1.WBRegWrite), 32'(erw_np));
      check($sformatf("v%0d.np_WBWriteData", mon_n), bus1.WBWriteData,  edata);
      if (ev)
        check($sformatf("v%0d.WBWriteReg", mon_n), 32'(bus0.WBWriteReg), 32'(ereg));
    end
  end

  localparam logic [31:0] RD  = 32'h80F17F22;
  localparam logic [31:0] PCV = 32'h00400008;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    void'(exp_q.pop_back());
    #1 rst = 1'b1;
    #2 check_all_zero("reset0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Sub-word loads: v rw wr m2r lt off alu rd pc st fl | ev erw np reg data
    drive(1, 1, 3, 1, 3'd1, 2'd1, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h0000007F);
    cyc  (1, 1, 3, 1, 3'd1, 2'd3, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'hFFFFFF80);
    cyc  (1, 1, 3, 1, 3'd2, 2'd3, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h00000080);
    cyc  (1, 1, 3, 1, 3'd3, 2'd2, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'hFFFF80F1);
    cyc  (1, 1, 3, 1, 3'd4, 2'd3, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h000080F1);
    cyc  (1, 1, 3, 1, 3'd0, 2'd0, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h80F17F22);
    cyc  (1, 1, 3, 1, 3'd7, 2'd2, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h80F17F22);
    cyc  (1, 1, 3, 1, 3'd1, 2'd0, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h00000022);
    cyc  (1, 1, 3, 1, 3'd3, 2'd1, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h00007F22);
    cyc  (1, 1, 3, 1, 3'd2, 2'd2, 0, RD, PCV, 0, 0, 1, 1, 1, 3, 32'h000000F1);
    // Source select on consecutive cycles
    cyc  (1, 1, 7, 0, 3'd0, 2'd0, 32'h1234, RD, PCV, 0, 0, 1, 1, 1, 7, 32'h00001234);
    cyc  (1, 1, 7, 2, 3'd0, 2'd0, 32'h1234, RD, PCV, 0, 0, 1, 1, 1, 7, 32'h00400008);
    cyc  (1, 1, 7, 3, 3'd0, 2'd0, 32'h1234, RD, PCV, 0, 0, 1, 1, 1, 7, 32'h00000000);
    // Register 0 protection, disabled write, invalid input
    cyc  (1, 1, 0, 0, 3'd0, 2'd0, 32'hFFFF, RD, PCV, 0, 0, 1, 0, 1, 0, 32'h0000FFFF);
    cyc  (1, 0, 9, 0, 3'd0, 2'd0, 32'h0042, RD, PCV, 0, 0, 1, 0, 0, 9, 32'h00000042);
    cyc  (0, 1, 4, 0, 3'd0, 2'd0, 32'h0055, RD, PCV, 0, 0, 0, 0, 0, 0, 32'h00000000);
    // Stall holds A, then stall+flush gives a bubble that a stall keeps
    cyc  (1, 1, 10, 0, 3'd0, 2'd0, 32'hA5A5, RD, PCV, 0, 0, 1, 1, 1, 10, 32'h0000A5A5);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 11, 0, 3'd0, 2'd0, 32'hBBBB, RD, PCV, 1, 0, 1, 1, 1, 10, 32'h0000A5A5);
    cyc  (1, 1, 11, 0, 3'd0, 2'd0, 32'hBBBB, RD, PCV, 1, 1, 0, 0, 0, 0, 32'h00000000);
    for (int i = 0; i < 2; i++)
      cyc(1, 1, 11, 0, 3'd0, 2'd0, 32'hBBBB, RD, PCV, 1, 0, 0, 0, 0, 0, 32'h00000000);
    cyc  (1, 1, 11, 0, 3'd0, 2'd0, 32'hBBBB, RD, PCV, 0, 0, 1, 1, 1, 11, 32'h0000BBBB);
    cyc  (1, 1, 12, 0, 3'd0, 2'd0, 32'hCCCC, RD, PCV, 0, 1, 0, 0, 0, 0, 32'h00000000);
    cyc  (1, 1, 13, 2, 3'd0, 2'd0, 32'hDDDD, RD, PCV, 0, 0, 1, 1, 1, 13, 32'h00400008);
    // Asynchronous reset mid-cycle with a valid instruction held
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 14, 0, 3'd0, 2'd0, 32'h0E0E, RD, PCV, 0, 0, 1, 1, 1, 14, 32'h00000E0E);
    cyc  (0, 0, 0, 0, 3'd0, 2'd0, 0, RD, PCV, 0, 0, 0, 0, 0, 0, 32'h00000000);
`ifdef WB_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // 5 retired, 2 counted bubbles (post-reset slot and one later), 3 stalled
    drive(1, 1, 1, 0, 3'd0, 2'd0, 32'd1, RD, PCV, 0, 0, 1, 1, 1, 1, 32'd1);
    cyc  (1, 1, 2, 0, 3'd0, 2'd0, 32'd2, RD, PCV, 0, 0, 1, 1, 1, 2, 32'd2);
    cyc  (1, 1, 3, 0, 3'd0, 2'd0, 32'd3, RD, PCV, 0, 0, 1, 1, 1, 3, 32'd3);
    cyc  (1, 1, 4, 0, 3'd0, 2'd0, 32'd4, RD, PCV, 0, 0, 1, 1, 1, 4, 32'd4);
    cyc  (1, 1, 5, 0, 3'd0, 2'd0, 32'd5, RD, PCV, 0, 0, 1, 1, 1, 5, 32'd5);
    cyc  (0, 0, 0, 0, 3'd0, 2'd0, 32'd0, RD, PCV, 0, 0, 0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 6, 0, 3'd0, 2'd0, 32'd6, RD, PCV, 1, 0, 0, 0, 0, 0, 32'd0);
    cyc  (0, 0, 0, 0, 3'd0, 2'd0, 32'd0, RD, PCV, 0, 0, 0, 0, 0, 0, 32'd0);
    @(negedge clk);
    check("perf.RetireCount", retire0, 32'd5);
    check("perf.BubbleCount", bubble0, 32'd2);
    check("perf.np_RetireCount", retire1, 32'd5);
    check("perf.np_BubbleCount", bubble1, 32'd2);
`endif
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered MEM/WB write-back stage for the 5-stage MIPS datapath.
- Captures MEM-stage results in a pipeline register with stall and flush control.
- Formats sub-word load data (LB/LBU/LH/LHU/LW) and selects the write-back source.
- Drives the register-file write port and the WB forwarding bus.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 16; byte lanes = DATA_W/8.
- REG_ADDR_W, 5, register-file address width.
- ZERO_REG_PROTECT, 1, when 1, writes to register 0 are suppressed.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous active-high reset.
- Stall  input  1  hold the stage register.
- Flush  input  1  insert a bubble; has priority over Stall.
- InValid  input  1  MEM-stage instruction valid.
- RegWrite  input  1  MEM-stage register write enable.
- WriteReg  input  REG_ADDR_W  destination register.
- MemToReg  input  2  source select: 0 ALU, 1 load, 2 PC link, 3 zero.
- LoadType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others behave as LW.
- ByteOffset  input  2  address[1:0] of the load.
- ALUResult  input  DATA_W  ALU result.
- ReadData  input  DATA_W  raw data-memory word.
- PC  input  DATA_W  link value, already computed upstream.
- WBValid  output  1  registered valid.
- WBRegWrite  output  1  qualified register-file write enable.
- WBWriteReg  output  REG_ADDR_W  registered destination.
- WBWriteData  output  DATA_W  formatted write-back data.

Behaviour:
- Reset: while Rst is high, all stage-register fields are cleared asynchronously. WBValid=0, WBRegWrite=0, WBWriteReg=0, WBWriteData=0. An instruction in flight when reset asserts is discarded.
- Stage register update per rising Clk, in priority order:
  - Flush=1: valid cleared; other fields don't-care.
  - else Stall=1: all fields hold.
  - else: all inputs captured, with valid taken from InValid.
- Latency: exactly 1 cycle from inputs to outputs. Outputs are combinational from registered fields only; there is no input-to-output combinational path.
- WBRegWrite = valid & RegWrite_q & ~(ZERO_REG_PROTECT & WriteReg_q==0).
- Load formatting uses registered fields, little-endian:
  - Byte lane = ReadData_q[8*ByteOffset_q +: 8].
  - Half lane = ReadData_q[16*ByteOffset_q[1] +: 16]; ByteOffset_q[0] is ignored.
  - LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
  - LW and undefined LoadType codes pass the word through unchanged.
- Source mux:
  - 0: ALUResult_q
  - 1: formatted load
  - 2: PC_q
  - 3: all zeros
- When valid=0, WBWriteData is forced to 0 and WBRegWrite=0.
- Simultaneous Stall and Flush: the flush wins and a bubble is produced.
- A stall while a bubble is held keeps the bubble; no spurious write occurs.
- Reset deassertion: the first capture happens on the first rising Clk edge after Rst falls.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - RetireCount (32): increments on each cycle where WBValid=1 and the stage register is not stalled, i.e. each instruction is counted once.
  - BubbleCount (32): increments on each unstalled cycle with WBValid=0.
- Both counters reset to 0 on Rst and wrap modulo 2^32.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - MemToReg encodings WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC=2, WB_SRC_ZERO=3.
  - LoadType encodings LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - Default DATA_W and REG_ADDR_W.
- One natural sub-module: load_formatter. It is purely combinational: ReadData, LoadType and ByteOffset in, formatted word out. It is instantiated once and reusable by the MEM stage.

Test Plan:
1. Rst high mid-run with a valid instruction in the register → all outputs 0 immediately, without waiting for a clock edge. After release, the first capture occurs on the next edge.
2. MemToReg=1, ReadData=0x80F17F22, LoadType:
   - LB, ByteOffset=1 → WBWriteData 0x0000007F.
   - LB, ByteOffset=3 → 0xFFFFFF80.
   - LBU, ByteOffset=3 → 0x00000080.
   - LH, ByteOffset=2 → 0xFFFF80F1.
   - LHU, ByteOffset=3 → 0x000080F1.
3. MemToReg 0/2/3 with ALUResult=0x1234, PC=0x00400008 → WBWriteData 0x1234, then 0x00400008, then 0 on consecutive cycles, each 1 cycle after input.
4. RegWrite=1, WriteReg=0, ALUResult=0xFFFF → WBRegWrite=0 when ZERO_REG_PROTECT=1; WBRegWrite=1 when ZERO_REG_PROTECT=0.
5. Valid instruction A captured, then Stall=1 for 3 cycles with new inputs B → outputs hold A. Then Stall=1 and Flush=1 together → WBValid=0 and WBRegWrite=0 on the next cycle.
6. With WB_PERF_CNT_EN: 5 valid, 2 bubble and 3 stalled cycles → RetireCount=5 and BubbleCount=2 (stalled cycles not counted). Preload near 0xFFFFFFFF → the counter wraps to 0.
